lzw_code_packer: RTL

Downstream stage of the LZW compression core. Accepts the variable-rate stream of CODE_WIDTH-bit dictionary codes the core emits, packs them MSB-first with no gaps into OUT_WIDTH-bit words, and presents those words on a valid/ready output toward the memory/DMA writer. On end-of-stream it flushes residual bits as a zero-padded final word, flagged with `word_last` and a valid-byte count.

---
 rtl/lzw_code_packer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lzw_code_packer.sv
// lzw_code_packer
//
// Packs a variable-rate stream of CODE_WIDTH-bit LZW codes MSB-first, with no
// gaps, into OUT_WIDTH-bit words on a valid/ready output. An end-of-stream
// flush emits the residual bits as a zero-padded final word (word_last_o=1,
// word_bytes_o = number of meaningful leading bytes). If the stream ends on an
// exact word boundary, an all-zero terminator word with word_bytes_o=0 is
// emitted instead.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   code_i         code from the LZW core
//   code_valid_i   code_i is valid
//   code_ready_o   packer accepts code_i this cycle
//   flush_i        end-of-stream marker, sampled only while code_ready_o=1
//   word_o         packed output word, first code bit at the MSB
//   word_valid_o   word_o is valid
//   word_ready_i   consumer accepts word_o
//   word_last_o    word_o is the final word of the stream
//   word_bytes_o   valid leading bytes in word_o
//   stream_codes_o codes accepted in the current stream, saturating at 0xFFFF

module lzw_code_packer #(
  parameter int CODE_WIDTH = 12,
  parameter int OUT_WIDTH  = 32,
  parameter int BUF_WIDTH  = 64,
  localparam int BYTES_W   = $clog2(OUT_WIDTH / 8) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CODE_WIDTH-1:0] code_i,
  input  logic                  code_valid_i,
  output logic                  code_ready_o,
  input  logic                  flush_i,
  output logic [OUT_WIDTH-1:0]  word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  word_last_o,
  output logic [BYTES_W-1:0]    word_bytes_o,
  output logic [15:0]           stream_codes_o
);

  localparam int FILL_W = $clog2(BUF_WIDTH + 1);
  localparam int FW1    = FILL_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LAST  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BUF_WIDTH-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [OUT_WIDTH-1:0]   word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic                   word_last_q, word_last_d;
  logic [BYTES_W-1:0]     word_bytes_q, word_bytes_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   out_free;
  logic                   has_full;
  logic                   accept;
  logic                   load_full;
  logic                   load_last;
  logic [FW1-1:0]         fill_plus_code;
  logic [FW1-1:0]         fill_round;
  logic [BUF_WIDTH-1:0]   buf_shift;
  logic [FILL_W-1:0]      fill_rem;
  logic [BUF_WIDTH-1:0]   code_aligned;

  // Readiness looks only at the registered fill; a drain in the same cycle is
  // deliberately not credited so the path stays short. Held low during reset.
  assign fill_plus_code = {1'b0, fill_q} + FW1'(CODE_WIDTH);
  assign code_ready_o   = rst_n && (state_q == ST_RUN) &&
                          (fill_plus_code <= FW1'(BUF_WIDTH));

  assign out_free  = !word_valid_q || word_ready_i;
  assign has_full  = fill_q >= FILL_W'(OUT_WIDTH);
  assign accept    = code_valid_i && code_ready_o;
  assign load_full = out_free && has_full && (state_q != ST_LAST);
  assign load_last = out_free && !has_full && (state_q == ST_FLUSH);

  // Bits beyond fill are always zero, so the top OUT_WIDTH bits already form
  // a correctly zero-padded partial word.
  assign fill_round = {1'b0, fill_q} + FW1'(7);

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    word_valid_d = word_valid_q && !word_ready_i;
    word_last_d  = word_last_q;
    word_bytes_d = word_bytes_q;
    cnt_d        = cnt_q;

    // Drain first, then append the new code directly under the remaining bits.
    buf_shift    = load_full ? (buf_q << OUT_WIDTH) : buf_q;
    fill_rem     = fill_q - (load_full ? FILL_W'(OUT_WIDTH) : FILL_W'(0));
    code_aligned = {code_i, {(BUF_WIDTH - CODE_WIDTH){1'b0}}} >> fill_rem;
    buf_d        = accept ? (buf_shift | code_aligned) : buf_shift;
    fill_d       = accept ? (fill_rem + FILL_W'(CODE_WIDTH)) : fill_rem;

    if (load_full) begin
      word_d       = buf_q[BUF_WIDTH-1 -: OUT_WIDTH];
      word_valid_d = 1'b1;
      word_last_d  = 1'b0;
      word_bytes_d = BYTES_W'(OUT_WIDTH / 8);
    end

    if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      ST_RUN: begin
        // A code accepted alongside flush still belongs to this stream.
        if (code_ready_o && flush_i) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Residue (or empty terminator when fill is 0) once full words are gone.
        if (load_last) begin
          word_d       = buf_q[BUF_WIDTH-1 -: OUT_WIDTH];
          word_valid_d = 1'b1;
          word_last_d  = 1'b1;
          word_bytes_d = BYTES_W'(fill_round >> 3);
          buf_d        = '0;
          fill_d       = '0;
          state_d      = ST_LAST;
        end
      end
      ST_LAST: begin
        if (word_valid_q && word_ready_i) begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      buf_q        <= '0;
      fill_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      word_bytes_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      word_bytes_q <= word_bytes_d;
      cnt_q        <= cnt_d;
    end
  end

  assign word_o         = word_q;
  assign word_valid_o   = word_valid_q;
  assign word_last_o    = word_last_q;
  assign word_bytes_o   = word_bytes_q;
  assign stream_codes_o = cnt_q;

endmodule
